// File: rtl/pipe_hold_ctrl.sv
// Pipeline hold/flush sequencer: merges ex/clint/rib/jtag hold sources into one hold code,
// extends jump flushes, sequences the jtag halt drain/ack and counts stalled cycles.
// Optional rib-hold watchdog is enabled by defining PIPE_HOLD_WDT_EN.
module pipe_hold_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned WDT_LIMIT    = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_flag_ex_i,
  input  logic        hold_flag_clint_i,
  input  logic        hold_flag_rib_i,
  input  logic        jtag_halt_flag_i,
  input  logic        stall_cnt_clr_i,
  output logic [2:0]  hold_flag_o,
  output logic        jump_flag_o,
  output logic [31:0] jump_addr_o,
  output logic        halted_o,
  output logic [31:0] stall_cnt_o
`ifdef PIPE_HOLD_WDT_EN
  ,
  output logic        wdt_timeout_o,
  input  logic        wdt_clr_i
`endif
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DATA_W = 32;

  // Hold_Flag_Bus encoding: None=0 < Pc=1 < If=2 < Id=3
  localparam logic [2:0] HOLD_NONE = 3'd0;
  localparam logic [2:0] HOLD_PC   = 3'd1;
  localparam logic [2:0] HOLD_ID   = 3'd3;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    flush_cnt, flush_nxt;
  logic [CNT_W-1:0]    drain_cnt, drain_nxt;
  logic [DATA_W-1:0]   stall_cnt;
  logic                flush_act;
  logic                hold_id;
  logic                hold_pc;
  logic                drain_go;
  logic [2:0]          hold_c;

  assign flush_act = jump_flag_i || (flush_cnt != '0);
  assign hold_id   = flush_act || hold_flag_ex_i || hold_flag_clint_i;
  assign hold_pc   = hold_flag_rib_i || (state == DRAIN) || (state == HALTED);
  // Drain only advances when nothing in the pipe is still settling.
  assign drain_go  = !hold_flag_ex_i && !hold_flag_clint_i && !flush_act;

  always_comb begin
    hold_c = HOLD_NONE;
    if (hold_id) begin
      hold_c = HOLD_ID;
    end else if (hold_pc) begin
      hold_c = HOLD_PC;
    end
  end

  always_comb begin
    flush_nxt = flush_cnt;
    if (jump_flag_i) begin
      flush_nxt = CNT_W'(FLUSH_CYCLES - 1);
    end else if (flush_cnt != '0) begin
      flush_nxt = flush_cnt - CNT_W'(1);
    end
  end

  // Halt sequencer next-state logic
  always_comb begin
    state_nxt = state;
    drain_nxt = drain_cnt;
    case (state)
      RUN: begin
        if (jtag_halt_flag_i) begin
          state_nxt = DRAIN;
          drain_nxt = CNT_W'(DRAIN_CYCLES);
        end
      end
      DRAIN: begin
        if (!jtag_halt_flag_i) begin
          state_nxt = RUN;
        end else if (drain_go) begin
          drain_nxt = drain_cnt - CNT_W'(1);
          if (drain_cnt == CNT_W'(1)) begin
            state_nxt = HALTED;
          end
        end
      end
      HALTED: begin
        if (!jtag_halt_flag_i) begin
          state_nxt = RUN;
        end
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= RUN;
      flush_cnt <= '0;
      drain_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_nxt;
      drain_cnt <= drain_nxt;
      if (stall_cnt_clr_i) begin
        stall_cnt <= '0;
      end else if ((hold_c != HOLD_NONE) && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + DATA_W'(1);
      end
    end
  end

  // Every output reads as idle while reset is held low.
  assign hold_flag_o = rst ? hold_c : HOLD_NONE;
  assign jump_flag_o = rst && jump_flag_i;
  assign jump_addr_o = rst ? jump_addr_i : '0;
  assign halted_o    = rst && (state == HALTED);
  assign stall_cnt_o = rst ? stall_cnt : '0;

`ifdef PIPE_HOLD_WDT_EN
  localparam int unsigned WDT_W = 16;

  logic [WDT_W-1:0] wdt_cnt;
  logic             wdt_flag;

  // Consecutive rib-hold watchdog; counter parks at the limit, flag is sticky
  always_ff @(posedge clk) begin
    if (!rst) begin
      wdt_cnt  <= '0;
      wdt_flag <= 1'b0;
    end else begin
      if (!hold_flag_rib_i) begin
        wdt_cnt <= '0;
      end else if (wdt_cnt != WDT_W'(WDT_LIMIT)) begin
        wdt_cnt <= wdt_cnt + WDT_W'(1);
      end
      if (wdt_clr_i) begin
        wdt_flag <= 1'b0;
      end else if (hold_flag_rib_i && (wdt_cnt == WDT_W'(WDT_LIMIT - 1))) begin
        wdt_flag <= 1'b1;
      end
    end
  end

  assign wdt_timeout_o = rst && wdt_flag;
`endif

endmodule
